ktane_irq_ctrl: RTL and testbench

KTANE_IRQ_CTRL -- requirements
Module: ktane_irq_ctrl

---
 rtl/ktane_irq_pkg.sv | 25 ++
 rtl/irq_sync_edge.sv | 27 ++
 rtl/ktane_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_ktane_irq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ktane_irq_pkg.sv
// Shared register map, FSM state type and priority helper for the KTANE interrupt controller.
package ktane_irq_pkg;

  localparam int unsigned MaxCh = 16;

  localparam logic [1:0] AddrPend   = 2'd0;
  localparam logic [1:0] AddrMask   = 2'd1;
  localparam logic [1:0] AddrMode   = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } irq_state_e;

  // Fixed priority: the lowest set index wins.
  function automatic logic [3:0] prio_idx(input logic [MaxCh-1:0] v);
    prio_idx = '0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (v[i]) prio_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One-bit 2-flop synchronizer followed by a history flop for rising-edge detection.
module irq_sync_edge (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/ktane_irq_ctrl.sv
// Interrupt controller: per-channel sync/edge detect, PEND/MASK/MODE/STATUS registers,
// fixed-priority arbitration and an IDLE/REQ/SERVICE handshake FSM towards the CPU.
module ktane_irq_ctrl
  import ktane_irq_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned VEC_W  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] irq_in_i,
  input  logic [1:0]        bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  input  logic              bus_we_i,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              irq_req_o,
  output logic [VEC_W-1:0]  irq_vec_o,
  input  logic              irq_ack_i,
  output logic              irq_active_o
);

  logic [NUM_CH-1:0] sync_lvl, sync_rise;
  logic [NUM_CH-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
  logic [NUM_CH-1:0] elig, elig_shift, w1c, ack_clr;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  irq_state_e        state_q, state_d;
  logic              wr_pend, wr_mask, wr_mode, wr_eoi, ack_take, vec_elig;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (irq_in_i[i]),
      .level_o (sync_lvl[i]),
      .rise_o  (sync_rise[i])
    );
  end

  if (DATA_W > NUM_CH) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata_i[DATA_W-1:NUM_CH];
  end

  assign wr_pend = bus_we_i && (bus_addr_i == AddrPend);
  assign wr_mask = bus_we_i && (bus_addr_i == AddrMask);
  assign wr_mode = bus_we_i && (bus_addr_i == AddrMode);
  assign wr_eoi  = bus_we_i && (bus_addr_i == AddrStatus);

  assign elig       = pend_q & ~mask_q;
  assign elig_shift = elig >> vec_q;
  assign vec_elig   = elig_shift[0];
  assign ack_take   = (state_q == StReq) && irq_ack_i;

  // Edge channels: set beats any clear. Level channels track the synchronized input.
  always_comb begin
    w1c     = wr_pend ? bus_wdata_i[NUM_CH-1:0] : '0;
    ack_clr = ack_take ? (NUM_CH'(1) << vec_q) : '0;
    pend_d  = (mode_q & ((pend_q & ~(w1c | ack_clr)) | sync_rise)) | (~mode_q & sync_lvl);
    mask_d  = wr_mask ? bus_wdata_i[NUM_CH-1:0] : mask_q;
    mode_d  = wr_mode ? bus_wdata_i[NUM_CH-1:0] : mode_q;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d = StReq;
          vec_d   = VEC_W'(prio_idx(MaxCh'(elig)));
        end
      end
      StReq: begin
        if (irq_ack_i)      state_d = StService;
        else if (!vec_elig) state_d = StIdle;
      end
      StService: begin
        if (wr_eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign irq_req_o    = (state_q == StReq);
  assign irq_active_o = (state_q == StService);
  assign irq_vec_o    = vec_q;

  always_comb begin
    rdata_d = '0;
    unique case (bus_addr_i)
      AddrPend:   rdata_d[NUM_CH-1:0] = pend_q;
      AddrMask:   rdata_d[NUM_CH-1:0] = mask_q;
      AddrMode:   rdata_d[NUM_CH-1:0] = mode_q;
      AddrStatus: rdata_d[VEC_W:0]    = {irq_active_o, vec_q};
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pend_q  <= '0;
      mask_q  <= '1;
      mode_q  <= '0;
      vec_q   <= '0;
      rdata_q <= '0;
      state_q <= StIdle;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      vec_q   <= vec_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
    end
  end

  assign bus_rdata_o = rdata_q;

endmodule

// File: tb/tb_ktane_irq_ctrl.sv
// Directed self-checking bench for ktane_irq_ctrl with hand-computed expectations.
module tb_ktane_irq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [1:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic [15:0] bus_rdata;
  logic        irq_req;
  logic [3:0]  irq_vec;
  logic        irq_ack;
  logic        irq_active;

  int n_cmp  = 0;
  int n_fail = 0;

  ktane_irq_ctrl #(
    .NUM_CH (8),
    .DATA_W (16),
    .VEC_W  (4)
  ) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .irq_in_i     (irq_in),
    .bus_addr_i   (bus_addr),
    .bus_wdata_i  (bus_wdata),
    .bus_we_i     (bus_we),
    .bus_rdata_o  (bus_rdata),
    .irq_req_o    (irq_req),
    .irq_vec_o    (irq_vec),
    .irq_ack_i    (irq_ack),
    .irq_active_o (irq_active)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    bus_addr = a;
    tick();
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_vec", 32'(irq_vec), 32'd0);
    check("rst_active", 32'(irq_active), 32'd0);
    check("rst_rdata", 32'(bus_rdata), 32'd0);
    bus_read(2'd1); check("rst_mask", 32'(bus_rdata), 32'h00FF);
    bus_read(2'd2); check("rst_mode", 32'(bus_rdata), 32'h0000);
    bus_read(2'd0); check("rst_pend", 32'(bus_rdata), 32'h0000);

    // Edge path on channel 0
    bus_write(2'd1, 16'h00FE);
    bus_write(2'd2, 16'h0001);
    bus_addr = 2'd0;
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick(); tick();
    check("edge_req_e3", 32'(irq_req), 32'd0);
    tick();
    check("edge_pend_e3", 32'(bus_rdata), 32'h0001);
    check("edge_req_e4", 32'(irq_req), 32'd1);
    check("edge_vec_e4", 32'(irq_vec), 32'd0);
    ack_pulse();
    check("edge_active", 32'(irq_active), 32'd1);
    check("edge_req_off", 32'(irq_req), 32'd0);
    bus_read(2'd0); check("edge_pend_clr", 32'(bus_rdata), 32'h0000);
    bus_read(2'd3); check("edge_status", 32'(bus_rdata), 32'h0010);
    bus_write(2'd3, 16'h0000);
    check("edge_eoi", 32'(irq_active), 32'd0);
    ack_pulse();
    check("ack_idle_ignored", 32'(irq_active), 32'd0);

    // Priority: channels 5 and 2 together
    bus_write(2'd1, 16'h0000);
    bus_write(2'd2, 16'h00FF);
    irq_in = 8'h24; tick();
    irq_in = 8'h00; tick(); tick(); tick();
    check("prio_req", 32'(irq_req), 32'd1);
    check("prio_vec_first", 32'(irq_vec), 32'd2);
    ack_pulse();
    bus_write(2'd3, 16'h0000);
    check("prio_eoi_idle", 32'(irq_req | irq_active), 32'd0);
    tick();
    check("prio_req2", 32'(irq_req), 32'd1);
    check("prio_vec_second", 32'(irq_vec), 32'd5);
    ack_pulse();
    bus_write(2'd3, 16'h0000);

    // Retract on channel 3, with no preemption by channel 1 beforehand
    irq_in = 8'h08; tick();
    irq_in = 8'h00; tick(); tick(); tick();
    check("ret_vec", 32'(irq_vec), 32'd3);
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick(); tick(); tick();
    check("nopreempt_req", 32'(irq_req), 32'd1);
    check("nopreempt_vec", 32'(irq_vec), 32'd3);
    bus_write(2'd1, 16'h0008);
    bus_addr = 2'd0;
    tick();
    check("ret_req_off", 32'(irq_req), 32'd0);
    check("ret_active_off", 32'(irq_active), 32'd0);
    tick();
    check("ret_pend", 32'(bus_rdata), 32'h000A);
    check("ret_next_vec", 32'(irq_vec), 32'd1);
    ack_pulse();
    bus_write(2'd3, 16'h0000);
    bus_write(2'd0, 16'h0008);

    // Level channel 1, all masked
    bus_write(2'd1, 16'h00FF);
    bus_write(2'd2, 16'h0000);
    irq_in = 8'h02; tick(); tick(); tick();
    bus_write(2'd0, 16'h0002);
    bus_read(2'd0); check("lvl_w1c_hold", 32'(bus_rdata), 32'h0002);
    tick();
    irq_in = 8'h00;
    tick(); tick(); tick();
    // bus_rdata trails PEND by one edge
    check("lvl_edge3", 32'(bus_rdata), 32'h0002);
    tick();
    check("lvl_dropped", 32'(bus_rdata), 32'h0000);

    // Set/clear collision on channel 4
    bus_write(2'd2, 16'h0010);
    irq_in = 8'h10; tick();
    irq_in = 8'h00; tick();
    bus_write(2'd0, 16'h0010);
    tick();
    check("collide_set_wins", 32'(bus_rdata), 32'h0010);
    bus_write(2'd0, 16'h0010);
    tick();
    check("w1c_clears", 32'(bus_rdata), 32'h0000);
    bus_write(2'd1, 16'hFFFF);
    bus_read(2'd1); check("mask_upper_ignored", 32'(bus_rdata), 32'h00FF);

    // Reset in the middle of service
    bus_write(2'd2, 16'h0001);
    bus_write(2'd1, 16'h00FE);
    irq_in = 8'h01; tick();
    irq_in = 8'h00; tick(); tick(); tick();
    ack_pulse();
    check("mid_active", 32'(irq_active), 32'd1);
    reset = 1'b1; tick();
    reset = 1'b0;
    check("mid_rst_active", 32'(irq_active), 32'd0);
    check("mid_rst_req", 32'(irq_req), 32'd0);
    bus_read(2'd1); check("mid_rst_mask", 32'(bus_rdata), 32'h00FF);
    bus_read(2'd3); check("mid_rst_status", 32'(bus_rdata), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
